// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: rename-to-RS dispatch with ROB tag allocation, routing and mispredict flush sequencing
//   clk, reset (sync, active-high)
//   valid_in/data_in/ready_in      : renamed uop in (rob_tag field of data_in ignored)
//   data_out, alu/br/mem_valid     : registered uop with rob_tag, one RS valid at a time
//   alu/br/mem_ready               : RS accept
//   rob_retire                     : ROB head retired
//   mispredict, recover_tag        : flush pulse and tag of the kept branch
//   rob_count                      : occupied ROB entries
//   stall_cycles                   : only with DISPATCH_STATS_EN defined
package dispatch_pkg;
  typedef struct packed {
    logic [15:0] payload;
    logic        fu_alu;
    logic        fu_br;
    logic        fu_mem;
    logic [7:0]  rob_tag;
  } rename_data;
endpackage

module dispatch_ctrl
  import dispatch_pkg::*;
#(
  parameter int ROB_DEPTH = 16,
  parameter int FLUSH_CYCLES = 2,
  localparam int TAG_W = $clog2(ROB_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  rename_data       data_in,
  output logic             ready_in,
  output rename_data       data_out,
  output logic             alu_valid,
  output logic             br_valid,
  output logic             mem_valid,
  input  logic             alu_ready,
  input  logic             br_ready,
  input  logic             mem_ready,
  input  logic             rob_retire,
  input  logic             mispredict,
  input  logic [TAG_W-1:0] recover_tag,
  output logic [TAG_W:0]   rob_count
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);
  localparam int CNT_W = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TAG_W:0] head_q, head_d, tail_q, tail_d;
  rename_data data_q, data_d;
  logic alu_q, alu_d, br_q, br_d, mem_q, mem_d;
  logic full, empty, out_fire, out_free, accept, retire;
  logic [TAG_W-1:0] rel;
  always_comb begin
    rob_count = tail_q - head_q;
    full = rob_count == (TAG_W+1)'(ROB_DEPTH);
    empty = rob_count == '0;
    out_fire = (alu_q && alu_ready) || (br_q && br_ready) || (mem_q && mem_ready);
    out_free = !(alu_q || br_q || mem_q) || out_fire;
    ready_in = state_q == RUN && out_free && !full && !mispredict;
    accept = valid_in && ready_in;
    retire = rob_retire && !empty;
    head_d = head_q + (TAG_W+1)'(retire);
    // Distance from the (post-retire) head to the tag after the branch; 0 means the ROB is exactly full.
    rel = recover_tag + 1'b1 - head_d[TAG_W-1:0];
    tail_d = mispredict ? head_d + {rel == '0, rel} : tail_q + (TAG_W+1)'(accept);
    data_d = data_q;
    if (accept) begin
      data_d = data_in;
      data_d.rob_tag = 8'(tail_q[TAG_W-1:0]);
    end
    br_d = mispredict ? 1'b0 : accept ? data_in.fu_br : br_q && !br_ready;
    mem_d = mispredict ? 1'b0 : accept ? data_in.fu_mem && !data_in.fu_br : mem_q && !mem_ready;
    alu_d = mispredict ? 1'b0 : accept ? data_in.fu_alu && !data_in.fu_br && !data_in.fu_mem : alu_q && !alu_ready;
    state_d = mispredict ? FLUSH : (state_q == FLUSH && cnt_q == '0) ? RUN : state_q;
    cnt_d = mispredict ? CNT_W'(FLUSH_CYCLES - 1) : state_q == FLUSH ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      data_q <= '0;
      alu_q <= 1'b0;
      br_q <= 1'b0;
      mem_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
      data_q <= data_d;
      alu_q <= alu_d;
      br_q <= br_d;
      mem_q <= mem_d;
    end
  end
  assign data_out = data_q;
  assign alu_valid = alu_q;
  assign br_valid = br_q;
  assign mem_valid = mem_q;
`ifdef DISPATCH_STATS_EN
  logic [31:0] stall_q, stall_d;
  always_comb stall_d = (valid_in && !ready_in && state_q == RUN && stall_q != '1) ? stall_q + 1'b1 : stall_q;
  always_ff @(posedge clk) stall_q <= reset ? '0 : stall_d;
  assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_dispatch_ctrl.sv
// tb_dispatch_ctrl: table vectors, directed corner sequences and random traffic against a queue-level model
module tb_dispatch_ctrl;
  import dispatch_pkg::*;
  localparam int D = 16, FC = 2;
  logic clk = 0, reset, valid_in, ready_in, alu_valid, br_valid, mem_valid;
  logic alu_ready, br_ready, mem_ready, rob_retire, mispredict;
  rename_data data_in, data_out;
  logic [3:0] recover_tag;
  logic [4:0] rob_count;
`ifdef DISPATCH_STATS_EN
  logic [31:0] stall_cycles;
`endif
  always #5 clk = ~clk;
  dispatch_ctrl #(.ROB_DEPTH(D), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in), .ready_in(ready_in),
    .data_out(data_out), .alu_valid(alu_valid), .br_valid(br_valid), .mem_valid(mem_valid),
    .alu_ready(alu_ready), .br_ready(br_ready), .mem_ready(mem_ready), .rob_retire(rob_retire),
    .mispredict(mispredict), .recover_tag(recover_tag), .rob_count(rob_count)
`ifdef DISPATCH_STATS_EN
    , .stall_cycles(stall_cycles)
`endif
  );
  int total = 0, bad = 0;
  int m_head, m_tail, m_hold, m_block, m_stall;
  rename_data m_data;
  logic o_ready, o_alu, o_br, o_mem;
  int o_tag, o_cnt;
  typedef struct {
    logic v; logic [2:0] fu; logic ret;
    logic e_rdy; logic [2:0] e_vld; int e_tag; int e_cnt;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_head = 0; m_tail = 0; m_hold = 0; m_block = 0; m_stall = 0; m_data = '0;
  endtask

  // fu and rdy are {br, mem, alu}; m_hold: 0 none, 1 alu, 2 br, 3 mem
  task automatic step(input logic v, input logic [2:0] fu, input logic [2:0] rdy, input logic ret,
                      input logic mis, input logic [3:0] rt, input logic [15:0] pay, input logic rst);
    int cnt, c;
    logic fire, er;
    valid_in = v;
    data_in = '{payload: pay, fu_alu: fu[0], fu_br: fu[2], fu_mem: fu[1], rob_tag: 8'($urandom)};
    {br_ready, mem_ready, alu_ready} = rdy;
    rob_retire = ret; mispredict = mis; recover_tag = rt; reset = rst;
    #1;
    cnt = (m_tail - m_head) & 31;
    fire = (m_hold == 1 && rdy[0]) || (m_hold == 2 && rdy[2]) || (m_hold == 3 && rdy[1]);
    er = m_block == 0 && (m_hold == 0 || fire) && cnt < D && !mis;
    chk("ready_in", ready_in, er);
    chk("alu_valid", alu_valid, m_hold == 1);
    chk("br_valid", br_valid, m_hold == 2);
    chk("mem_valid", mem_valid, m_hold == 3);
    chk("data_out", data_out, m_data);
    chk("rob_count", rob_count, cnt);
`ifdef DISPATCH_STATS_EN
    chk("stall_cycles", stall_cycles, m_stall);
`endif
    o_ready = ready_in; o_alu = alu_valid; o_br = br_valid; o_mem = mem_valid;
    o_tag = data_out.rob_tag; o_cnt = rob_count;
    if (rst) model_reset();
    else begin
      if (v && !er && m_block == 0) m_stall++;
      if (ret && cnt > 0) m_head = (m_head + 1) & 31;
      if (mis) begin
        c = (rt + 1 - m_head) & 15;
        if (c == 0) c = D;
        m_tail = (m_head + c) & 31;
        m_hold = 0;
        m_block = FC;
      end else begin
        if (m_block > 0) m_block--;
        if (v && er) begin
          m_data = data_in;
          m_data.rob_tag = 8'(m_tail & 15);
          m_hold = fu[2] ? 2 : fu[1] ? 3 : fu[0] ? 1 : 0;
          m_tail = (m_tail + 1) & 31;
        end else if (fire) m_hold = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1; valid_in = 0; rob_retire = 0; mispredict = 0; recover_tag = 0; data_in = '0;
    {alu_ready, br_ready, mem_ready} = 3'b111;
    repeat (2) @(negedge clk);
    model_reset();
  endtask

  initial begin
    tbl[0] = '{1, 3'b001, 0, 1, 3'b000, 0, 0};
    tbl[1] = '{1, 3'b100, 0, 1, 3'b001, 0, 1};
    tbl[2] = '{1, 3'b010, 0, 1, 3'b100, 1, 2};
    tbl[3] = '{1, 3'b001, 0, 1, 3'b010, 2, 3};
    tbl[4] = '{0, 3'b000, 0, 1, 3'b001, 3, 4};
    tbl[5] = '{0, 3'b000, 0, 1, 3'b000, 3, 4};
    tbl[6] = '{1, 3'b001, 1, 1, 3'b000, 3, 4};
    tbl[7] = '{0, 3'b000, 0, 1, 3'b001, 4, 4};
    do_reset();
    chk("rst_count", rob_count, 0);
    chk("rst_valids", {br_valid, mem_valid, alu_valid}, 0);
    chk("rst_data", data_out, 0);
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, tbl[i].fu, 3'b111, tbl[i].ret, 0, 0, 16'(i + 1), 0);
      chk($sformatf("tbl%0d_ready", i), o_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_vld", i), {o_br, o_mem, o_alu}, tbl[i].e_vld);
      chk($sformatf("tbl%0d_tag", i), o_tag, tbl[i].e_tag);
      chk($sformatf("tbl%0d_cnt", i), o_cnt, tbl[i].e_cnt);
    end
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 3'b001, 3'b111, 0, 0, 0, 16'(i), 0);
    step(1, 3'b001, 3'b111, 1, 0, 0, 16'h55, 0);
    chk("full_cnt", o_cnt, 16);
    chk("full_ready", o_ready, 0);
    step(1, 3'b001, 3'b111, 0, 0, 0, 16'h66, 0);
    chk("after_ret_cnt", o_cnt, 15);
    chk("after_ret_ready", o_ready, 1);
    step(0, 3'b000, 3'b111, 0, 0, 0, 0, 0);
    chk("wrap_tag", o_tag, 0);
    chk("wrap_cnt", o_cnt, 16);
    do_reset();
    step(1, 3'b010, 3'b101, 0, 0, 0, 16'hbeef, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 3'b001, 3'b101, 0, 0, 0, 16'h1234, 0);
      chk("bp_mem", o_mem, 1);
      chk("bp_tag", o_tag, 0);
      chk("bp_ready", o_ready, 0);
    end
    step(1, 3'b001, 3'b111, 0, 0, 0, 16'h4321, 0);
    chk("bp_release_ready", o_ready, 1);
    step(0, 3'b000, 3'b111, 0, 0, 0, 0, 0);
    chk("bp_next_alu", o_alu, 1);
    chk("bp_next_tag", o_tag, 1);
    do_reset();
    for (int i = 0; i < 9; i++) step(1, 3'b001, 3'b111, 0, 0, 0, 16'(i), 0);
    step(1, 3'b001, 3'b111, 0, 1, 4'd5, 16'h77, 0);
    chk("mp_ready", o_ready, 0);
    step(1, 3'b001, 3'b111, 0, 0, 0, 16'h78, 0);
    chk("mp_vld", {o_br, o_mem, o_alu}, 0);
    chk("mp_ready1", o_ready, 0);
    chk("mp_cnt", o_cnt, 6);
    step(1, 3'b001, 3'b111, 0, 0, 0, 16'h79, 0);
    chk("mp_ready2", o_ready, 0);
    step(1, 3'b001, 3'b111, 0, 0, 0, 16'h7a, 0);
    chk("mp_ready3", o_ready, 1);
    step(0, 3'b000, 3'b111, 0, 0, 0, 0, 0);
    chk("mp_tag", o_tag, 6);
    chk("mp_cnt2", o_cnt, 7);
`ifdef DISPATCH_STATS_EN
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 3'b001, 3'b111, 0, 0, 0, 16'(i), 0);
    for (int i = 0; i < 5; i++) step(1, 3'b001, 3'b111, 0, 0, 0, 16'(i), 0);
    chk("stall5", stall_cycles, 5);
`endif
    do_reset();
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 7, 3'($urandom), 3'($urandom | $urandom), $urandom_range(0, 9) < 4,
           $urandom_range(0, 99) < 3, 4'($urandom), 16'($urandom), i == 1500);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
